// File: rtl/lsu_controller_pkg.sv
// Shared types and helpers for the load/store sequencer.
`default_nettype none

package lsu_controller_pkg;

  typedef enum logic [2:0] {
    OP     = 3'd0,
    OP_IMM = 3'd1,
    LOAD   = 3'd2,
    STORE  = 3'd3,
    BRANCH = 3'd4,
    JAL    = 3'd5,
    JALR   = 3'd6,
    LUI    = 3'd7
  } op_type_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT0 = 2'd1,
    BEAT1 = 2'd2,
    FIN   = 2'd3
  } lsu_state_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  function automatic logic [2:0] lsu_size(input logic [2:0] funct3);
    case (funct3[1:0])
      2'b00:   lsu_size = 3'd1;
      2'b01:   lsu_size = 3'd2;
      default: lsu_size = 3'd4;
    endcase
  endfunction

  function automatic logic lsu_f3_legal(input logic is_store, input logic [2:0] funct3);
    if (is_store)
      lsu_f3_legal = (funct3 == F3_SB) || (funct3 == F3_SH) || (funct3 == F3_SW);
    else
      lsu_f3_legal = (funct3 == F3_LB) || (funct3 == F3_LH) || (funct3 == F3_LW) ||
                     (funct3 == F3_LBU) || (funct3 == F3_LHU);
  endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_controller_load_ext.sv
// Sign/zero extension of a byte-0-aligned load word according to funct3.
`default_nettype none

module lsu_controller_load_ext
  import lsu_controller_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_word,
  input  logic [2:0]       i_funct3,
  output logic [WIDTH-1:0] o_data
);

  always_comb begin
    o_data = '0;
    case (i_funct3)
      F3_LB:  o_data = {{(WIDTH-8){i_word[7]}}, i_word[7:0]};
      F3_LH:  o_data = {{(WIDTH-16){i_word[15]}}, i_word[15:0]};
      F3_LW:  o_data = i_word;
      F3_LBU: o_data = {{(WIDTH-8){1'b0}}, i_word[7:0]};
      F3_LHU: o_data = {{(WIDTH-16){1'b0}}, i_word[15:0]};
      default: o_data = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/lsu_controller.sv
// Load/store sequencer: aligns sub-word accesses, splits misaligned ones into two word beats.
`default_nettype none

module lsu_controller
  import lsu_controller_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  op_type_t          op_type,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]  wdata,
  output logic              busy,
  output logic              done,
  output logic [WIDTH-1:0]  rdata,
  output logic              err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [WIDTH-1:0]  mem_wdata,
  input  logic              mem_ack,
  input  logic [WIDTH-1:0]  mem_rdata
);

  lsu_state_t r_state, w_next;

  logic              r_is_store;
  logic              r_err;
  logic [2:0]        r_funct3;
  logic [ADDR_W-1:0] r_addr;
  logic [WIDTH-1:0]  r_wdata;
  logic [WIDTH-1:0]  r_buf_lo;
  logic [WIDTH-1:0]  r_buf_hi;

  logic                 w_is_ls;
  logic                 w_is_store_in;
  logic                 w_legal;
  logic [1:0]           w_off;
  logic [2:0]           w_size;
  logic [3:0]           w_end;
  logic                 w_split;
  logic [3:0]           w_mask;
  logic [7:0]           w_be_wide;
  logic [2*WIDTH-1:0]   w_wd_wide;
  logic [ADDR_W-1:0]    w_word;
  logic [WIDTH-1:0]     w_aligned;
  logic [WIDTH-1:0]     w_ext;

  assign w_is_store_in = (op_type == STORE);
  assign w_is_ls       = start && ((op_type == LOAD) || (op_type == STORE));
  assign w_legal       = lsu_f3_legal(w_is_store_in, funct3);

  assign w_off   = r_addr[1:0];
  assign w_size  = lsu_size(r_funct3);
  assign w_end   = {2'b00, w_off} + {1'b0, w_size};
  assign w_split = (w_end > 4'd4);
  assign w_word  = {r_addr[ADDR_W-1:2], 2'b00};

  always_comb begin
    case (w_size)
      3'd1:    w_mask = 4'b0001;
      3'd2:    w_mask = 4'b0011;
      default: w_mask = 4'b1111;
    endcase
  end

  // Low halves feed beat 0, the spill-over high halves feed beat 1.
  assign w_be_wide = {4'b0000, w_mask} << w_off;
  assign w_wd_wide = {{WIDTH{1'b0}}, r_wdata} << {w_off, 3'b000};

  always_comb begin
    case (w_off)
      2'd0:    w_aligned = r_buf_lo;
      2'd1:    w_aligned = {r_buf_hi[7:0],  r_buf_lo[WIDTH-1:8]};
      2'd2:    w_aligned = {r_buf_hi[15:0], r_buf_lo[WIDTH-1:16]};
      default: w_aligned = {r_buf_hi[23:0], r_buf_lo[WIDTH-1:24]};
    endcase
  end

  lsu_controller_load_ext #(
    .WIDTH (WIDTH)
  ) u_load_ext (
    .i_word   (w_aligned),
    .i_funct3 (r_funct3),
    .o_data   (w_ext)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_is_ls) w_next = w_legal ? BEAT0 : FIN;
      BEAT0:   if (mem_ack) w_next = w_split ? BEAT1 : FIN;
      BEAT1:   if (mem_ack) w_next = FIN;
      FIN:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_is_store <= 1'b0;
      r_err      <= 1'b0;
      r_funct3   <= 3'b000;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_buf_lo   <= '0;
      r_buf_hi   <= '0;
    end else begin
      if (r_state == IDLE && w_is_ls) begin
        r_is_store <= w_is_store_in;
        r_err      <= !w_legal;
        r_funct3   <= funct3;
        r_addr     <= addr;
        r_wdata    <= wdata;
        r_buf_hi   <= '0;
      end
      if (r_state == BEAT0 && mem_ack) r_buf_lo <= mem_rdata;
      if (r_state == BEAT1 && mem_ack) r_buf_hi <= mem_rdata;
    end
  end

  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_be    = 4'b0000;
    mem_wdata = '0;
    done      = 1'b0;
    err       = 1'b0;
    rdata     = '0;
    case (r_state)
      BEAT0: begin
        mem_req   = 1'b1;
        mem_we    = r_is_store;
        mem_addr  = w_word;
        mem_be    = w_be_wide[3:0];
        mem_wdata = w_wd_wide[WIDTH-1:0];
      end
      BEAT1: begin
        mem_req   = 1'b1;
        mem_we    = r_is_store;
        mem_addr  = w_word + ADDR_W'(4);
        mem_be    = w_be_wide[7:4];
        mem_wdata = w_wd_wide[2*WIDTH-1:WIDTH];
      end
      FIN: begin
        done  = 1'b1;
        err   = r_err;
        rdata = (r_is_store || r_err) ? '0 : w_ext;
      end
      default: ;
    endcase
  end

  // Combinational so the core stalls in the very cycle it presents the op.
  assign busy = w_is_ls && !done;

endmodule

`default_nettype wire

// File: tb/tb_lsu_controller.sv
// Directed, table-driven bench for lsu_controller with a small word memory model.
`default_nettype none

module tb_lsu_controller;
  import lsu_controller_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  op_type_t    op_type;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy, done, err, mem_req, mem_we, mem_ack;
  logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  int ack_delay;
  int ack_cnt;
  logic ack_force;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lsu_controller #(.WIDTH(32), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op_type(op_type), .funct3(funct3),
    .addr(addr), .wdata(wdata), .busy(busy), .done(done), .rdata(rdata), .err(err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    case (a)
      32'h100: mem_rd = 32'h44332211;
      32'h104: mem_rd = 32'h88776655;
      32'h200: mem_rd = 32'h80FFFFFF;
      default: mem_rd = 32'h0;
    endcase
  endfunction

  assign mem_rdata = mem_rd(mem_addr);
  assign mem_ack   = (mem_req && (ack_cnt == ack_delay)) || ack_force;

  always @(posedge clk) begin
    if (rst || !mem_req || mem_ack) ack_cnt <= 0;
    else                            ack_cnt <= ack_cnt + 1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  typedef struct {
    op_type_t    op;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          delay;
    int          lat;
    int          beats;
    logic [31:0] a0;
    logic [3:0]  be0;
    logic [31:0] wd0;
    logic [31:0] a1;
    logic [3:0]  be1;
    logic [31:0] wd1;
    logic        we;
    logic [31:0] rd;
    logic        err;
  } vec_t;

  vec_t vecs[14];

  task automatic run_vec(input int idx, input vec_t v);
    int nb;
    logic got;
    logic prev_ack;
    logic [31:0] ba[2];
    logic [3:0]  bbe[2];
    logic [31:0] bwd[2];
    logic        bwe[2];
    nb = 0; got = 1'b0; prev_ack = 1'b1;
    for (int j = 0; j < 2; j++) begin ba[j] = '0; bbe[j] = '0; bwd[j] = '0; bwe[j] = 1'b0; end
    @(posedge clk); #1;
    start = 1'b1; op_type = v.op; funct3 = v.f3; addr = v.addr; wdata = v.wdata;
    ack_delay = v.delay;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (mem_req) begin
        if (prev_ack) begin
          if (nb < 2) begin ba[nb] = mem_addr; bbe[nb] = mem_be; bwd[nb] = mem_wdata; bwe[nb] = mem_we; end
          nb++;
        end else if (nb <= 2) begin
          chk($sformatf("v%0d stable_addr", idx), mem_addr, ba[nb-1]);
          chk($sformatf("v%0d stable_be", idx), {28'h0, mem_be}, {28'h0, bbe[nb-1]});
        end
      end
      prev_ack = mem_req ? mem_ack : 1'b1;
      if (done) begin
        got = 1'b1;
        chk($sformatf("v%0d latency", idx), k, v.lat);
        chk($sformatf("v%0d rdata", idx), rdata, v.rd);
        chk($sformatf("v%0d err", idx), {31'h0, err}, {31'h0, v.err});
        chk($sformatf("v%0d busy_at_done", idx), {31'h0, busy}, 32'h0);
        break;
      end else begin
        chk($sformatf("v%0d busy", idx), {31'h0, busy}, 32'h1);
      end
      @(posedge clk); #1;
    end
    if (!got) chk($sformatf("v%0d done_timeout", idx), 32'h0, 32'h1);
    chk($sformatf("v%0d beats", idx), nb, v.beats);
    if (v.beats >= 1) begin
      chk($sformatf("v%0d addr0", idx), ba[0], v.a0);
      chk($sformatf("v%0d be0", idx), {28'h0, bbe[0]}, {28'h0, v.be0});
      chk($sformatf("v%0d we0", idx), {31'h0, bwe[0]}, {31'h0, v.we});
      if (v.we) chk($sformatf("v%0d wdata0", idx), bwd[0], v.wd0);
    end
    if (v.beats == 2) begin
      chk($sformatf("v%0d addr1", idx), ba[1], v.a1);
      chk($sformatf("v%0d be1", idx), {28'h0, bbe[1]}, {28'h0, v.be1});
      chk($sformatf("v%0d we1", idx), {31'h0, bwe[1]}, {31'h0, v.we});
      if (v.we) chk($sformatf("v%0d wdata1", idx), bwd[1], v.wd1);
    end
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  initial begin
    //         op     f3      addr    wdata         dly lat bt a0      be0     wd0           a1      be1     wd1           we    rdata         err
    vecs[0]  = '{LOAD,  F3_LW,  32'h100, 32'h0,        0, 2, 1, 32'h100, 4'b1111, 32'h0,        32'h0,   4'b0000, 32'h0,        1'b0, 32'h44332211, 1'b0};
    vecs[1]  = '{LOAD,  F3_LB,  32'h203, 32'h0,        0, 2, 1, 32'h200, 4'b1000, 32'h0,        32'h0,   4'b0000, 32'h0,        1'b0, 32'hFFFFFF80, 1'b0};
    vecs[2]  = '{LOAD,  F3_LBU, 32'h203, 32'h0,        0, 2, 1, 32'h200, 4'b1000, 32'h0,        32'h0,   4'b0000, 32'h0,        1'b0, 32'h00000080, 1'b0};
    vecs[3]  = '{LOAD,  F3_LW,  32'h102, 32'h0,        0, 3, 2, 32'h100, 4'b1100, 32'h0,        32'h104, 4'b0011, 32'h0,        1'b0, 32'h66554433, 1'b0};
    vecs[4]  = '{STORE, F3_SH,  32'h103, 32'h0000ABCD, 0, 3, 2, 32'h100, 4'b1000, 32'hCD000000, 32'h104, 4'b0001, 32'h000000AB, 1'b1, 32'h0,        1'b0};
    vecs[5]  = '{LOAD,  F3_LW,  32'h100, 32'h0,        3, 5, 1, 32'h100, 4'b1111, 32'h0,        32'h0,   4'b0000, 32'h0,        1'b0, 32'h44332211, 1'b0};
    vecs[6]  = '{LOAD,  3'b011, 32'h100, 32'h0,        0, 1, 0, 32'h0,   4'b0000, 32'h0,        32'h0,   4'b0000, 32'h0,        1'b0, 32'h0,        1'b1};
    vecs[7]  = '{LOAD,  F3_LH,  32'h202, 32'h0,        0, 2, 1, 32'h200, 4'b1100, 32'h0,        32'h0,   4'b0000, 32'h0,        1'b0, 32'hFFFF80FF, 1'b0};
    vecs[8]  = '{LOAD,  F3_LHU, 32'h202, 32'h0,        0, 2, 1, 32'h200, 4'b1100, 32'h0,        32'h0,   4'b0000, 32'h0,        1'b0, 32'h000080FF, 1'b0};
    vecs[9]  = '{LOAD,  F3_LH,  32'h203, 32'h0,        0, 3, 2, 32'h200, 4'b1000, 32'h0,        32'h204, 4'b0001, 32'h0,        1'b0, 32'h00000080, 1'b0};
    vecs[10] = '{STORE, F3_SW,  32'h101, 32'h12345678, 0, 3, 2, 32'h100, 4'b1110, 32'h34567800, 32'h104, 4'b0001, 32'h00000012, 1'b1, 32'h0,        1'b0};
    vecs[11] = '{STORE, F3_SB,  32'h102, 32'h000000AB, 0, 2, 1, 32'h100, 4'b0100, 32'h00AB0000, 32'h0,   4'b0000, 32'h0,        1'b1, 32'h0,        1'b0};
    vecs[12] = '{STORE, 3'b011, 32'h100, 32'h0,        0, 1, 0, 32'h0,   4'b0000, 32'h0,        32'h0,   4'b0000, 32'h0,        1'b0, 32'h0,        1'b1};
    vecs[13] = '{LOAD,  F3_LW,  32'h103, 32'h0,        1, 5, 2, 32'h100, 4'b1000, 32'h0,        32'h104, 4'b0111, 32'h0,        1'b0, 32'h77665544, 1'b0};

    rst = 1'b1; start = 1'b0; op_type = OP; funct3 = 3'b000; addr = '0; wdata = '0;
    ack_delay = 0; ack_force = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset busy", {31'h0, busy}, 32'h0);
    chk("reset done", {31'h0, done}, 32'h0);
    chk("reset err", {31'h0, err}, 32'h0);
    chk("reset mem_req", {31'h0, mem_req}, 32'h0);
    chk("reset mem_be", {28'h0, mem_be}, 32'h0);
    chk("reset mem_addr", mem_addr, 32'h0);
    chk("reset rdata", rdata, 32'h0);
    rst = 1'b0;

    for (int i = 0; i < 14; i++) run_vec(i, vecs[i]);

    // Non-memory op type: no stall, no activity.
    @(posedge clk); #1;
    start = 1'b1; op_type = OP; funct3 = F3_LW; addr = 32'h100;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("op busy", {31'h0, busy}, 32'h0);
      chk("op mem_req", {31'h0, mem_req}, 32'h0);
      chk("op done", {31'h0, done}, 32'h0);
    end
    @(posedge clk); #1;
    start = 1'b0;

    // Stray ack while idle must not start anything.
    ack_force = 1'b1;
    @(posedge clk); #1;
    ack_force = 1'b0;
    @(negedge clk);
    chk("stray_ack mem_req", {31'h0, mem_req}, 32'h0);
    chk("stray_ack done", {31'h0, done}, 32'h0);

    // start dropped after the first cycle: the access still completes.
    begin
      logic seen;
      seen = 1'b0;
      @(posedge clk); #1;
      start = 1'b1; op_type = LOAD; funct3 = F3_LW; addr = 32'h104; ack_delay = 2;
      @(posedge clk); #1;
      start = 1'b0;
      for (int k = 1; k < 20 && !seen; k++) begin
        @(negedge clk);
        if (done) begin
          seen = 1'b1;
          chk("drop latency", k, 4);
          chk("drop rdata", rdata, 32'h88776655);
        end
        @(posedge clk); #1;
      end
      if (!seen) chk("drop done_timeout", 32'h0, 32'h1);
    end

    // Reset during BEAT1 of a split load aborts without a done pulse.
    begin
      logic in_b1;
      logic pulsed;
      in_b1 = 1'b0; pulsed = 1'b0;
      @(posedge clk); #1;
      start = 1'b1; op_type = LOAD; funct3 = F3_LW; addr = 32'h102; ack_delay = 3;
      for (int k = 0; k < 20 && !in_b1; k++) begin
        @(negedge clk);
        if (mem_req && mem_addr == 32'h104) in_b1 = 1'b1;
        else begin @(posedge clk); #1; end
      end
      chk("rst_b1 reached_beat1", {31'h0, in_b1}, 32'h1);
      @(posedge clk); #1;
      chk("rst_b1 still_beat1", mem_addr, 32'h104);
      rst = 1'b1; start = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("rst_b1 mem_req", {31'h0, mem_req}, 32'h0);
      chk("rst_b1 done", {31'h0, done}, 32'h0);
      for (int k = 0; k < 6; k++) begin
        @(negedge clk);
        if (done || mem_req) pulsed = 1'b1;
      end
      chk("rst_b1 no_done", {31'h0, pulsed}, 32'h0);
    end

    // Controller is usable again after the abort.
    run_vec(100, vecs[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
